// File: rtl/ler_janela.sv
// Read stage of the coprocessor: fetches the 3x3 neighbourhood around one pixel
// from image RAM, zero-padding outside neighbours, and presents it as one word.
module ler_janela #(
  parameter int LARGURA = 64,
  parameter int ALTURA  = 64,
  parameter int COORD_W = 6,
  parameter int ADDR_W  = 12,
  parameter int PIXEL_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COORD_W-1:0]     centro_x,
  input  logic [COORD_W-1:0]     centro_y,
  input  logic [ADDR_W-1:0]      endereco_base,
  output logic [ADDR_W-1:0]      rdaddress,
  output logic                   rden,
  input  logic [PIXEL_W-1:0]     q,
  output logic [9*PIXEL_W-1:0]   janela,
  output logic                   done,
  output logic                   busy
);

  // Two extra bits: one for the sign of nx/ny, one so centre+1 never overflows.
  localparam int CW = COORD_W + 2;
  localparam logic signed [CW-1:0] ONE_S  = CW'(1);
  localparam logic signed [CW-1:0] ZERO_S = '0;
  localparam logic signed [CW-1:0] LARG_S = CW'(LARGURA);
  localparam logic signed [CW-1:0] ALT_S  = CW'(ALTURA);
  localparam logic [ADDR_W-1:0]    LARG_A = ADDR_W'(LARGURA);

  typedef enum logic [1:0] {
    IDLE,
    LEITURA,
    ESPERA,
    FIM
  } state_t;

  state_t state_reg, state_next;

  logic [3:0]          k_reg;
  logic [1:0]          col_reg;
  logic [1:0]          row_reg;
  logic [COORD_W-1:0]  cx_reg;
  logic [COORD_W-1:0]  cy_reg;
  logic [ADDR_W-1:0]   base_reg;

  logic signed [CW-1:0] nx;
  logic signed [CW-1:0] ny;
  logic                 in_range;
  logic [ADDR_W-1:0]    addr;

  logic       s1_valid_reg, s2_valid_reg;
  logic       s1_pad_reg,   s2_pad_reg;
  logic [3:0] s1_slot_reg,  s2_slot_reg;

  logic [9*PIXEL_W-1:0] shadow_reg;
  logic [9*PIXEL_W-1:0] window_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LEITURA;
      LEITURA: if (k_reg == 4'd8) state_next = ESPERA;
      ESPERA:  state_next = FIM;
      FIM:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Slot counter plus its column/row decomposition, so dx/dy need no division.
  always_ff @(posedge clock) begin
    if (reset) begin
      k_reg    <= '0;
      col_reg  <= '0;
      row_reg  <= '0;
      cx_reg   <= '0;
      cy_reg   <= '0;
      base_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      k_reg    <= '0;
      col_reg  <= '0;
      row_reg  <= '0;
      cx_reg   <= centro_x;
      cy_reg   <= centro_y;
      base_reg <= endereco_base;
    end else if (state_reg == LEITURA) begin
      k_reg <= k_reg + 4'd1;
      if (col_reg == 2'd2) begin
        col_reg <= '0;
        row_reg <= row_reg + 2'd1;
      end else begin
        col_reg <= col_reg + 2'd1;
      end
    end
  end

  always_comb begin
    nx = $signed({2'b00, cx_reg}) + $signed({{COORD_W{1'b0}}, col_reg}) - ONE_S;
    ny = $signed({2'b00, cy_reg}) + $signed({{COORD_W{1'b0}}, row_reg}) - ONE_S;
    in_range = (nx >= ZERO_S) && (nx < LARG_S) && (ny >= ZERO_S) && (ny < ALT_S);
    addr = base_reg + ADDR_W'($unsigned(ny)) * LARG_A + ADDR_W'($unsigned(nx));
  end

  // Out-of-range slots issue no read and leave rdaddress untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      rden      <= 1'b0;
      rdaddress <= '0;
    end else begin
      rden <= (state_reg == LEITURA) && in_range;
      if (state_reg == LEITURA && in_range) begin
        rdaddress <= addr;
      end
    end
  end

  // Slot tag travels two stages to line up with q coming back from the RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_pad_reg   <= 1'b0;
      s1_slot_reg  <= '0;
      s2_valid_reg <= 1'b0;
      s2_pad_reg   <= 1'b0;
      s2_slot_reg  <= '0;
    end else begin
      s1_valid_reg <= (state_reg == LEITURA);
      s1_pad_reg   <= !in_range;
      s1_slot_reg  <= k_reg;
      s2_valid_reg <= s1_valid_reg;
      s2_pad_reg   <= s1_pad_reg;
      s2_slot_reg  <= s1_slot_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_slot
      assign window_next[gi*PIXEL_W +: PIXEL_W] =
        (s2_valid_reg && s2_slot_reg == 4'(gi)) ? (s2_pad_reg ? '0 : q)
                                                : shadow_reg[gi*PIXEL_W +: PIXEL_W];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_reg <= '0;
    end else begin
      shadow_reg <= window_next;
    end
  end

  // The last slot lands in the same edge as the commit, so janela takes the merged word.
  always_ff @(posedge clock) begin
    if (reset) begin
      janela <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      if (state_reg == FIM) begin
        janela <= window_next;
      end
      done <= (state_reg == FIM);
      busy <= (state_reg != IDLE);
    end
  end

endmodule
